cbus_rr_arbiter: RTL and testbench

- Shares the single cache-bus (cbus) master port to the memory/AXI bridge between NUM_REQ cache-side requesters (index 0 = ICache, index 1 = DCache by default).
- Grants one requester at a time with round-robin priority.
- Holds the grant for the full burst until the final beat completes.
- Routes responses to the granted requester only, and tracks beat count for burst-length checking.

---
 rtl/cbus_rr_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_cbus_rr_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cbus_rr_arbiter.sv
// Round-robin arbiter that shares one cache-bus master port between
// NUM_REQ cache-side requesters. A grant is held for the whole burst and
// released on the final ready&last beat. The beat count is checked against
// the requested burst length, and any disagreement raises a sticky flag.

package cbus_pkg;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } cbus_size_t;

  // Burst length encoded as (beats - 1)
  typedef enum logic [3:0] {
    MLEN1  = 4'd0,
    MLEN2  = 4'd1,
    MLEN4  = 4'd3,
    MLEN8  = 4'd7,
    MLEN16 = 4'd15
  } cbus_len_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    cbus_size_t  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    cbus_len_t   len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

endpackage

module cbus_rr_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  cbus_req_t        ireqs  [NUM_REQ],
  output cbus_resp_t       iresps [NUM_REQ],
  output cbus_req_t        oreq,
  input  cbus_resp_t       oresp,
  output logic             busy,
  output logic [IDX_W-1:0] grant_idx,
  output logic             len_err
);

  // One extra bit so that (index + offset) can be wrapped modulo NUM_REQ
  // for requester counts that are not a power of two.
  localparam int SUM_W = IDX_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] rr_ptr_next;
  logic [IDX_W-1:0] grant_next;
  logic [3:0]       beat_cnt;
  logic [3:0]       beat_cnt_next;
  logic             len_err_next;

  logic             found;
  logic [IDX_W-1:0] winner;
  logic [SUM_W-1:0] cand;
  logic [SUM_W-1:0] ptr_sum;
  logic [IDX_W-1:0] ptr_after_grant;
  logic [4:0]       beats_seen;
  logic [4:0]       beats_expected;

  // Round-robin scan: first valid requester starting at rr_ptr wins
  always_comb begin
    found  = 1'b0;
    winner = rr_ptr;
    cand   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr} + SUM_W'(i);
      if (cand >= SUM_W'(NUM_REQ)) begin
        cand = cand - SUM_W'(NUM_REQ);
      end
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && cand == SUM_W'(j) && ireqs[j].valid) begin
          found  = 1'b1;
          winner = cand[IDX_W-1:0];
        end
      end
    end
  end

  // Pointer to the requester after the current grant, wrapped modulo NUM_REQ
  always_comb begin
    ptr_sum = {1'b0, grant_idx} + SUM_W'(1);
    if (ptr_sum >= SUM_W'(NUM_REQ)) begin
      ptr_sum = '0;
    end
    ptr_after_grant = ptr_sum[IDX_W-1:0];
  end

  // Datapath: pass the granted request out and its response back while BUSY
  always_comb begin
    oreq = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      iresps[k] = '0;
    end
    if (state == BUSY) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (grant_idx == IDX_W'(k)) begin
          oreq      = ireqs[k];
          iresps[k] = oresp;
        end
      end
    end
  end

  // Next-state logic: arbitration, beat counting and burst completion
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves a value unassigned and no latch is inferred.
    state_next     = state;
    rr_ptr_next    = rr_ptr;
    grant_next     = grant_idx;
    beat_cnt_next  = beat_cnt;
    len_err_next   = len_err;
    beats_seen     = {1'b0, beat_cnt} + 5'd1;
    beats_expected = {1'b0, oreq.len} + 5'd1;

    case (state)
      IDLE: begin
        if (found) begin
          state_next    = BUSY;
          grant_next    = winner;
          beat_cnt_next = '0;
        end
      end
      BUSY: begin
        // last without ready is not a beat and is ignored
        if (oresp.ready) begin
          beat_cnt_next = beat_cnt + 4'd1;
          if (oresp.last) begin
            state_next    = IDLE;
            rr_ptr_next   = ptr_after_grant;
            beat_cnt_next = '0;
            if (beats_seen != beats_expected) begin
              len_err_next = 1'b1;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
      beat_cnt  <= '0;
      len_err   <= 1'b0;
    end else begin
      state     <= state_next;
      rr_ptr    <= rr_ptr_next;
      grant_idx <= grant_next;
      beat_cnt  <= beat_cnt_next;
      len_err   <= len_err_next;
    end
  end

  assign busy = (state == BUSY);

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Self-checking bench for cbus_rr_arbiter: directed scenarios followed by a
// randomized phase, all compared against a transaction-level reference model.
module tb_cbus_rr_arbiter;
  import cbus_pkg::*;

  localparam int N  = 2;
  localparam int IW = 1;

  logic           clk = 1'b0;
  logic           reset;
  cbus_req_t      ireqs  [N];
  cbus_resp_t     iresps [N];
  cbus_req_t      oreq;
  cbus_resp_t     oresp;
  logic           busy;
  logic [IW-1:0]  grant_idx;
  logic           len_err;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: who owns the bus, who is next in line, beats so far
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_next  = 0;
  int m_beats = 0;
  bit m_err   = 1'b0;

  cbus_rr_arbiter #(.NUM_REQ(N), .IDX_W(IW)) dut (
    .clk       (clk),
    .reset     (reset),
    .ireqs     (ireqs),
    .iresps    (iresps),
    .oreq      (oreq),
    .oresp     (oresp),
    .busy      (busy),
    .grant_idx (grant_idx),
    .len_err   (len_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic int beats_of(cbus_len_t l);
    case (l)
      MLEN1:   return 1;
      MLEN2:   return 2;
      MLEN4:   return 4;
      MLEN8:   return 8;
      MLEN16:  return 16;
      default: return 0;
    endcase
  endfunction

  function automatic cbus_req_t mk_req(logic v, logic wr, cbus_size_t sz, logic [31:0] a,
                                       logic [3:0] st, logic [31:0] d, cbus_len_t l);
    cbus_req_t r;
    r.valid = v; r.is_write = wr; r.size = sz; r.addr = a;
    r.strobe = st; r.data = d; r.len = l;
    return r;
  endfunction

  function automatic cbus_resp_t mk_resp(logic rdy, logic lst, logic [31:0] d);
    cbus_resp_t r;
    r.ready = rdy; r.last = lst; r.data = d;
    return r;
  endfunction

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transaction-level update applied at every rising edge
  task automatic model_step();
    if (reset) begin
      m_busy = 1'b0; m_owner = 0; m_next = 0; m_beats = 0; m_err = 1'b0;
    end else if (!m_busy) begin
      for (int i = 0; i < N; i++) begin
        int c;
        c = (m_next + i) % N;
        if (ireqs[c].valid) begin
          m_busy = 1'b1; m_owner = c; m_beats = 0;
          break;
        end
      end
    end else if (oresp.ready) begin
      m_beats++;
      if (oresp.last) begin
        if (m_beats != beats_of(ireqs[m_owner].len)) m_err = 1'b1;
        m_busy  = 1'b0;
        m_next  = (m_owner + 1) % N;
        m_beats = 0;
      end
    end
  endtask

  task automatic check_outputs(string tag);
    cbus_req_t exp_req;
    exp_req = m_busy ? ireqs[m_owner] : '0;
    chk({tag, "_busy"}, busy, m_busy);
    chk({tag, "_len_err"}, len_err, m_err);
    chk({tag, "_oreq"}, oreq, exp_req);
    if (m_busy) chk({tag, "_grant"}, grant_idx, m_owner);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("%s_iresp%0d", tag, k), iresps[k],
          (m_busy && k == m_owner) ? oresp : '0);
    end
  endtask

  // Check at the falling edge, then advance one clock
  task automatic step(string tag);
    @(negedge clk);
    check_outputs(tag);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic step_nc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < N; k++) ireqs[k] = '0;
    oresp = '0;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    clear_inputs();
    step_nc();
    step_nc();
    reset = 1'b0;
  endtask

  initial begin
    cbus_len_t  lens [N];
    int         exp_g [3];
    int         n;
    logic       rdy;
    cbus_len_t  rl;

    reset = 1'b1;
    clear_inputs();
    reset_dut();

    // Reset state
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant", grant_idx, 0);
    chk("rst_len_err", len_err, 1'b0);
    chk("rst_oreq", oreq, '0);

    // Single 4-beat read from requester 0
    ireqs[0] = mk_req(1, 0, MSIZE4, 32'h1000, 4'hF, 32'h0, MLEN4);
    #1;
    chk("t1_c1_busy", busy, 1'b0);
    chk("t1_c1_valid", oreq.valid, 1'b0);
    step("t1_arb");
    chk("t1_c2_busy", busy, 1'b1);
    chk("t1_c2_grant", grant_idx, 0);
    chk("t1_c2_addr", oreq.addr, 32'h1000);
    for (int b = 0; b < 4; b++) begin
      oresp = mk_resp(1, b == 3, 32'hA0 + b);
      #1;
      chk("t1_beat_data", iresps[0].data, 32'hA0 + b);
      chk("t1_other", iresps[1], '0);
      step("t1_beat");
    end
    ireqs[0] = '0;
    oresp = '0;
    #1;
    chk("t1_done_busy", busy, 1'b0);
    chk("t1_done_len_err", len_err, 1'b0);
    step("t1_idle");

    // Two continuously valid requesters alternate, one IDLE cycle apart
    reset_dut();
    lens[0] = MLEN4;
    lens[1] = MLEN1;
    ireqs[0] = mk_req(1, 0, MSIZE4, 32'h2000, 4'hF, 32'h0, MLEN4);
    ireqs[1] = mk_req(1, 0, MSIZE4, 32'h3000, 4'hF, 32'h0, MLEN1);
    exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 0;
    for (int g = 0; g < 3; g++) begin
      step("t2_arb");
      chk("t2_busy", busy, 1'b1);
      chk("t2_grant", grant_idx, exp_g[g]);
      n = beats_of(lens[exp_g[g]]);
      for (int b = 0; b < n; b++) begin
        oresp = mk_resp(1, b == n - 1, 32'hB0 + b);
        step("t2_beat");
      end
      oresp = '0;
      #1;
      chk("t2_gap_busy", busy, 1'b0);
    end

    // Stall: last without ready is ignored
    reset_dut();
    ireqs[1] = mk_req(1, 0, MSIZE4, 32'h4000, 4'hF, 32'h0, MLEN1);
    step("t3_arb");
    chk("t3_grant", grant_idx, 1);
    oresp = mk_resp(0, 1, 32'h55);
    for (int c = 0; c < 5; c++) begin
      step("t3_stall");
      chk("t3_stall_busy", busy, 1'b1);
      chk("t3_stall_rdy0", iresps[0].ready, 1'b0);
      chk("t3_stall_rdy1", iresps[1].ready, 1'b0);
    end
    oresp = mk_resp(1, 1, 32'h66);
    step("t3_last");
    ireqs[1] = '0;
    oresp = '0;
    #1;
    chk("t3_done_busy", busy, 1'b0);
    chk("t3_len_err", len_err, 1'b0);

    // Short burst: last on beat 2 of a 4-beat request
    reset_dut();
    ireqs[0] = mk_req(1, 0, MSIZE4, 32'h1100, 4'hF, 32'h0, MLEN4);
    step("t4_arb");
    oresp = mk_resp(1, 0, 32'h1);
    step("t4_b1");
    oresp = mk_resp(1, 1, 32'h2);
    step("t4_b2");
    ireqs[0] = '0;
    oresp = '0;
    #1;
    chk("t4_err_set", len_err, 1'b1);
    ireqs[1] = mk_req(1, 0, MSIZE4, 32'h1200, 4'hF, 32'h0, MLEN1);
    step("t4_arb2");
    oresp = mk_resp(1, 1, 32'h3);
    step("t4_ok");
    ireqs[1] = '0;
    oresp = '0;
    #1;
    chk("t4_err_sticky", len_err, 1'b1);
    reset_dut();
    chk("t4_err_cleared", len_err, 1'b0);

    // Reset in the middle of a burst
    ireqs[0] = mk_req(1, 0, MSIZE4, 32'h1300, 4'hF, 32'h0, MLEN4);
    step("t5_arb");
    for (int b = 0; b < 2; b++) begin
      oresp = mk_resp(1, 0, 32'hC0 + b);
      step("t5_beat");
    end
    reset = 1'b1;
    step_nc();
    reset = 1'b0;
    clear_inputs();
    #1;
    chk("t5_busy", busy, 1'b0);
    chk("t5_oreq", oreq, '0);
    ireqs[1] = mk_req(1, 0, MSIZE4, 32'h1400, 4'hF, 32'h0, MLEN1);
    step("t5_arb2");
    chk("t5_grant", grant_idx, 1);
    chk("t5_busy2", busy, 1'b1);
    oresp = mk_resp(1, 1, 32'h7);
    step("t5_last");
    clear_inputs();

    // Single-beat uncached write passes through unchanged
    reset_dut();
    ireqs[1] = mk_req(1, 1, MSIZE4, 32'h5004, 4'b0011, 32'hDEADBEEF, MLEN1);
    step("t6_arb");
    chk("t6_oreq", oreq, mk_req(1, 1, MSIZE4, 32'h5004, 4'b0011, 32'hDEADBEEF, MLEN1));
    oresp = mk_resp(1, 1, 32'h0);
    step("t6_last");
    clear_inputs();
    #1;
    chk("t6_busy", busy, 1'b0);
    chk("t6_len_err", len_err, 1'b0);

    // Randomized traffic against the model
    reset_dut();
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < N; k++) begin
        if (m_busy && m_owner == k) begin
          if ($urandom_range(0, 19) == 0) ireqs[k].valid = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          case ($urandom_range(0, 2))
            0:       rl = MLEN1;
            1:       rl = MLEN2;
            default: rl = MLEN4;
          endcase
          ireqs[k] = mk_req($urandom_range(0, 4) < 3, 1'($urandom), cbus_size_t'($urandom_range(0, 3)),
                            $urandom, 4'($urandom), $urandom, rl);
        end
      end
      if (m_busy) begin
        rdy = ($urandom_range(0, 2) != 0);
        oresp = mk_resp(rdy,
                        rdy ? ((m_beats + 1 >= beats_of(ireqs[m_owner].len)) ||
                               ($urandom_range(0, 15) == 0))
                            : 1'($urandom),
                        $urandom);
      end else begin
        oresp = mk_resp(0, 1'($urandom), $urandom);
      end
      step("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
